grid_scan_display: RTL and testbench
====================================

GRID_SCAN_DISPLAY -- requirements
Module: grid_scan_display

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 50000, giving the clock cycles each row is held; legal range 2..2^20.
REQ-002 clk  input  1  Single system clock; all state SHALL be clocked on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low reset.
REQ-004 grid  input  64  Evolved 8x8 board from the evolve stage; row r = grid[8r+7:8r], column c = bit 8r+c; 1 = live cell.
REQ-005 grid_valid  input  1  One-cycle strobe; grid is sampled on any cycle where grid_valid=1.
REQ-006 blank  input  1  When 1, row_sel SHALL be forced to 0; scanning continues.
REQ-007 row_sel  output  8  One-hot active-high row enable.
REQ-008 col_data  output  8  Column data for the enabled row; 1 = LED on.
REQ-009 frame_done  output  1  One-cycle pulse at each frame boundary.
REQ-010 alive_count  output  7  Population count, 0..64, of the currently displayed frame.

Function
REQ-011 States SHALL be IDLE (no frame loaded) and SCAN.
- IDLE: row_sel=0, col_data=0.
- IDLE->SCAN on the first grid_valid; that grid SHALL load directly into the display buffer.
- The following cycle SHALL be row 0, dwell count 0.
REQ-012 In SCAN, a dwell counter SHALL count 0..CLK_DIV-1.
- At CLK_DIV-1 it SHALL wrap to 0 and advance row_idx.
- row_idx SHALL wrap from 7 to 0.
REQ-013 Registered outputs in SCAN:
- row_sel = (1 << row_idx) unless blank.
- col_data = display buffer row row_idx.
- Both outputs SHALL change only on a row advance or a buffer swap.
REQ-014 Double buffering: grid_valid in SCAN SHALL write grid into a pending register and set pending_flag; the displayed frame SHALL NOT change mid-frame.
REQ-015 The frame boundary is the cycle with row_idx=7 and dwell=CLK_DIV-1.
- frame_done SHALL pulse 1 on that cycle.
- If pending_flag=1, pending SHALL copy into the display buffer and pending_flag SHALL clear.
- Row 0 of the new frame SHALL show the new data.
REQ-016 grid_valid on the boundary cycle SHALL bypass pending: that grid becomes the displayed frame and pending_flag SHALL end at 0.
REQ-017 Several grid_valid strobes within one frame: the last one SHALL win; earlier grids SHALL be discarded.
REQ-018 alive_count SHALL update exactly one cycle after every display-buffer load, including the IDLE load. Between loads it SHALL hold.
REQ-019 Toggling blank SHALL NOT affect the counters, row_idx, the buffers or frame_done.

Reset
REQ-020 Asserting reset at any time, including mid-frame, SHALL immediately set the following: state=IDLE, dwell=0, row_idx=0, display buffer=0, pending=0, pending_flag=0, row_sel=0, col_data=0, frame_done=0, alive_count=0.
REQ-021 After reset deasserts, the block SHALL remain in IDLE until the next grid_valid.

Structure
REQ-022 Shared package SHALL hold:
- GRID_ROWS=8 and GRID_COLS=8 constants;
- the scan state enum {IDLE, SCAN};
- a grid-row extraction function used by this block and the evolve datapath.
REQ-023 Population count SHALL be a separate combinational sub-module, popcount64 (64-bit in, 7-bit out), whose output is registered in this block.
REQ-024 Dwell counter width SHALL be $clog2(CLK_DIV).

Verification (CLK_DIV=4)
REQ-025 Reset, then grid=64'h0000_0000_0000_00FF with grid_valid for 1 cycle:
- next cycle: row_sel=8'h01, col_data=8'hFF;
- following cycle: alive_count=8;
- 4 cycles later: row_sel=8'h02, col_data=8'h00.
REQ-026 Display 64'h8040_2010_0804_0201, then strobe 64'hFFFF_FFFF_FFFF_FFFF during row 3:
- rows 3..7 still show the diagonal;
- frame_done pulses after the row-7 dwell;
- next row 0 shows col_data=8'hFF;
- alive_count=64 one cycle after the swap.
REQ-027 Strobe 64'h1 in row 2 and 64'h2 in row 5 of the same frame -> the next frame shows row 0 col_data=8'h02 and alive_count=1.
REQ-028 Strobe 64'h0F on the exact boundary cycle -> the next row 0 shows 8'h0F and pending_flag=0.
REQ-029 Assert reset during row 4 -> all outputs are 0 in the same cycle; after release, the block stays idle with row_sel=0 until grid_valid.
REQ-030 Hold blank=1 for 2 full frames -> row_sel=0 throughout, frame_done still pulses every 32 cycles, and row_idx continues on release.

Source files
------------

// File: rtl/grid_scan_display_pkg.sv
// Shared definitions for the 8x8 grid datapath: board geometry, scan state
// encoding and the row-extraction helper used by both evolve and display.
package grid_scan_display_pkg;

    localparam int GRID_ROWS  = 8;
    localparam int GRID_COLS  = 8;
    localparam int GRID_BITS  = GRID_ROWS * GRID_COLS;
    localparam int ROW_IDX_W  = $clog2(GRID_ROWS);
    localparam int POP_W      = $clog2(GRID_BITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Row r occupies bits [8r+7:8r]; column c of that row is bit 8r+c.
    function automatic logic [GRID_COLS-1:0] grid_row(
        input logic [GRID_BITS-1:0] g,
        input logic [ROW_IDX_W-1:0] r
    );
        return g[int'(r) * GRID_COLS +: GRID_COLS];
    endfunction

endpackage

// File: rtl/grid_scan_display_popcount64.sv
// Combinational population count of a 64-bit board; the caller registers
// the result.
module popcount64
    import grid_scan_display_pkg::*;
(
    input  logic [GRID_BITS-1:0] i_bits,
    output logic [POP_W-1:0]     o_count
);

    logic [POP_W-1:0] w_sum;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < GRID_BITS; i++) begin
            w_sum = w_sum + {{(POP_W-1){1'b0}}, i_bits[i]};
        end
    end

    assign o_count = w_sum;

endmodule

// File: rtl/grid_scan_display.sv
// Row-multiplexed LED driver for an 8x8 board: double-buffered frames, one
// row held for CLK_DIV cycles, swap of a pending frame only at the frame boundary.
module grid_scan_display
    import grid_scan_display_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GRID_BITS-1:0] grid,
    input  logic                 grid_valid,
    input  logic                 blank,
    output logic [GRID_ROWS-1:0] row_sel,
    output logic [GRID_COLS-1:0] col_data,
    output logic                 frame_done,
    output logic [POP_W-1:0]     alive_count
);

    localparam int             DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_MAX = DW'(CLK_DIV - 1);

    scan_state_t            r_state;
    logic [DW-1:0]          r_dwell;
    logic [ROW_IDX_W-1:0]   r_row_idx;
    logic [GRID_BITS-1:0]   r_disp;
    logic [GRID_BITS-1:0]   r_pending;
    logic                   r_pending_flag;
    logic [GRID_ROWS-1:0]   r_row_sel;
    logic [GRID_COLS-1:0]   r_col_data;
    logic [POP_W-1:0]       r_alive;

    scan_state_t            w_state_next;
    logic [DW-1:0]          w_dwell_next;
    logic [ROW_IDX_W-1:0]   w_row_next;
    logic [GRID_BITS-1:0]   w_disp_next;
    logic [GRID_BITS-1:0]   w_pending_next;
    logic                   w_pending_flag_next;
    logic [GRID_ROWS-1:0]   w_row_sel_next;
    logic [GRID_COLS-1:0]   w_col_data_next;
    logic                   w_boundary;
    logic [POP_W-1:0]       w_pop;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (grid_valid) w_state_next = SCAN;
            SCAN:    w_state_next = SCAN;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_dwell_next        = r_dwell;
        w_row_next          = r_row_idx;
        w_disp_next         = r_disp;
        w_pending_next      = r_pending;
        w_pending_flag_next = r_pending_flag;
        w_boundary          = 1'b0;

        case (r_state)
            IDLE: begin
                if (grid_valid) begin
                    w_disp_next  = grid;
                    w_dwell_next = '0;
                    w_row_next   = '0;
                end
            end
            SCAN: begin
                w_boundary = (r_row_idx == ROW_IDX_W'(GRID_ROWS - 1)) && (r_dwell == DWELL_MAX);
                if (r_dwell == DWELL_MAX) begin
                    w_dwell_next = '0;
                    w_row_next   = r_row_idx + 1'b1;
                end else begin
                    w_dwell_next = r_dwell + 1'b1;
                end
                // A strobe landing on the boundary itself outranks anything pending.
                if (w_boundary) begin
                    if (grid_valid) begin
                        w_disp_next = grid;
                    end else if (r_pending_flag) begin
                        w_disp_next = r_pending;
                    end
                    w_pending_flag_next = 1'b0;
                end else if (grid_valid) begin
                    w_pending_next      = grid;
                    w_pending_flag_next = 1'b1;
                end
            end
            default: ;
        endcase

        w_row_sel_next  = '0;
        w_col_data_next = '0;
        if (w_state_next == SCAN) begin
            w_col_data_next = grid_row(w_disp_next, w_row_next);
            if (!blank) begin
                w_row_sel_next = {{(GRID_ROWS-1){1'b0}}, 1'b1} << w_row_next;
            end
        end
    end

    popcount64 u_popcount (
        .i_bits  (r_disp),
        .o_count (w_pop)
    );

    // NOTE: the display and pending buffers are plain registers, so they are reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dwell        <= '0;
            r_row_idx      <= '0;
            r_disp         <= '0;
            r_pending      <= '0;
            r_pending_flag <= 1'b0;
            r_row_sel      <= '0;
            r_col_data     <= '0;
            r_alive        <= '0;
        end else begin
            r_dwell        <= w_dwell_next;
            r_row_idx      <= w_row_next;
            r_disp         <= w_disp_next;
            r_pending      <= w_pending_next;
            r_pending_flag <= w_pending_flag_next;
            r_row_sel      <= w_row_sel_next;
            r_col_data     <= w_col_data_next;
            // Display buffer only changes on a load, so this trails each load by one cycle and holds otherwise.
            r_alive        <= w_pop;
        end
    end

    assign row_sel     = r_row_sel;
    assign col_data    = r_col_data;
    assign frame_done  = w_boundary;
    assign alive_count = r_alive;

endmodule

// File: tb/tb_grid_scan_display.sv
// Directed bench for grid_scan_display with CLK_DIV=4 (32-cycle frames);
// expected values are hand-derived cycle positions within each frame.
module tb_grid_scan_display;

    logic        clk;
    logic        reset;
    logic [63:0] grid;
    logic        grid_valid;
    logic        blank;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic [6:0]  alive_count;

    int n_total;
    int n_pass;

    grid_scan_display #(.CLK_DIV(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .grid        (grid),
        .grid_valid  (grid_valid),
        .blank       (blank),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done),
        .alive_count (alive_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [63:0] g);
        grid       = g;
        grid_valid = 1'b1;
        tick();
        grid_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        skip(2);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sel_or;
        int         fd_count;
        int         fd_bad;

        n_total    = 0;
        n_pass     = 0;
        reset      = 1'b0;
        grid       = '0;
        grid_valid = 1'b0;
        blank      = 1'b0;

        skip(3);
        check("rst_row_sel", row_sel, 0);
        check("rst_col_data", col_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_alive", alive_count, 0);
        reset = 1'b1;
        skip(4);
        check("idle_row_sel", row_sel, 0);

        // Single-row load from IDLE; C1 is the first cycle after the load edge.
        strobe(64'h0000_0000_0000_00FF);
        check("t1_c1_row_sel", row_sel, 8'h01);
        check("t1_c1_col", col_data, 8'hFF);
        check("t1_c1_alive_lag", alive_count, 0);
        tick();
        check("t1_c2_alive", alive_count, 8);
        skip(3);
        check("t1_c5_row_sel", row_sel, 8'h02);
        check("t1_c5_col", col_data, 8'h00);

        // Diagonal frame, new grid strobed mid-frame during row 3.
        do_reset();
        strobe(64'h8040_2010_0804_0201);
        check("t2_c1_col", col_data, 8'h01);
        skip(12);
        check("t2_c13_row_sel", row_sel, 8'h08);
        strobe(64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_c14_col", col_data, 8'h08);
        skip(3);
        check("t2_row4_col", col_data, 8'h10);
        skip(4);
        check("t2_row5_col", col_data, 8'h20);
        skip(4);
        check("t2_row6_col", col_data, 8'h40);
        skip(4);
        check("t2_row7_col", col_data, 8'h80);
        check("t2_row7_sel", row_sel, 8'h80);
        skip(2);
        check("t2_c31_fd_low", frame_done, 0);
        tick();
        check("t2_c32_fd_high", frame_done, 1);
        tick();
        check("t2_c33_row_sel", row_sel, 8'h01);
        check("t2_c33_col", col_data, 8'hFF);
        check("t2_c33_fd_low", frame_done, 0);
        check("t2_c33_alive_old", alive_count, 8);
        tick();
        check("t2_c34_alive", alive_count, 64);

        // Two strobes in one frame: second one wins.
        skip(7);
        strobe(64'h1);
        skip(11);
        strobe(64'h2);
        check("t3_c54_col_unchanged", col_data, 8'hFF);
        skip(11);
        check("t3_c65_row_sel", row_sel, 8'h01);
        check("t3_c65_col", col_data, 8'h02);
        tick();
        check("t3_c66_alive", alive_count, 1);

        // Pending strobe, then a strobe exactly on the boundary cycle.
        skip(3);
        strobe(64'hAA);
        skip(26);
        check("t4_c96_fd", frame_done, 1);
        strobe(64'h0F);
        check("t4_c97_col", col_data, 8'h0F);
        tick();
        check("t4_c98_alive", alive_count, 4);
        skip(31);
        check("t4_c129_col_no_stale", col_data, 8'h0F);
        check("t4_c129_alive", alive_count, 4);

        // Blank for two full frames.
        blank    = 1'b1;
        sel_or   = '0;
        fd_count = 0;
        fd_bad   = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            sel_or |= row_sel;
            if (frame_done) begin
                fd_count++;
                if (((129 + k) - 128) % 32 != 0) fd_bad++;
            end
        end
        check("t5_blank_row_sel", sel_or, 0);
        check("t5_fd_count", fd_count, 2);
        check("t5_fd_position", fd_bad, 0);
        check("t5_col_during_blank", col_data, 8'h0F);
        blank = 1'b0;
        tick();
        check("t5_c194_row_sel", row_sel, 8'h01);
        skip(4);
        check("t5_c198_row_sel", row_sel, 8'h02);
        check("t5_c198_col", col_data, 8'h00);

        // Reset mid-row 4.
        skip(11);
        check("t6_c209_row_sel", row_sel, 8'h10);
        reset = 1'b0;
        #1;
        check("t6_async_row_sel", row_sel, 0);
        check("t6_async_col", col_data, 0);
        check("t6_async_fd", frame_done, 0);
        check("t6_async_alive", alive_count, 0);
        tick();
        reset  = 1'b1;
        sel_or = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            sel_or |= row_sel;
        end
        check("t6_idle_after_release", sel_or, 0);
        strobe(64'hFF00);
        check("t6_reload_row_sel", row_sel, 8'h01);
        check("t6_reload_col", col_data, 8'h00);
        skip(4);
        check("t6_row1_row_sel", row_sel, 8'h02);
        check("t6_row1_col", col_data, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
